// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_pkg
// Purpose  : Shared width helpers and saturation constants for the FP library.
// Revision : 1.0 - initial release
// ============================================================================
package fp_pkg;

    // Bits needed to hold a leading-sign count of 0..w-1.
    function automatic int sh_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    function automatic logic [63:0] sat_max_m(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min_m(input int w);
        return 64'd1 << (w - 1);
    endfunction

    function automatic logic [63:0] sat_max_e(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_lsc.sv
`default_nettype none
// ============================================================================
// Module   : fp_lsc
// Purpose  : Combinational leading-sign counter (bits below the MSB equal to it).
// Revision : 1.0 - initial release
// ============================================================================
module fp_lsc
    import fp_pkg::*;
#(
    parameter int MW = 16
) (
    input  logic [MW-1:0]           m,
    output logic [sh_width(MW)-1:0] sh
);

    localparam int c_shw = sh_width(MW);

    logic done;

    always_comb begin
        sh   = '0;
        done = 1'b0;
        for (int i = MW - 2; i >= 0; i--) begin
            if (!done && (m[i] == m[MW-1])) begin
                sh = sh + c_shw'(1);
            end else begin
                done = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_norm_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fp_norm_pipe
// Purpose  : Two-stage valid/ready normaliser: round/pre-shift, then justify.
// Revision : 1.0 - initial release
// ============================================================================
module fp_norm_pipe
    import fp_pkg::*;
#(
    parameter int MW  = 16,
    parameter int EW  = 8,
    parameter int SAT = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [MW:0]   in_m,
    input  logic [EW-1:0] in_e,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [MW-1:0] out_m,
    output logic [EW-1:0] out_e,
    output logic          out_ovf,
    output logic          out_unf,
    input  logic          clr_sticky,
    output logic          ovf_sticky,
    output logic          unf_sticky
);

    localparam int            c_shw   = sh_width(MW);
    localparam logic [MW-1:0] c_max_m = MW'(sat_max_m(MW));
    localparam logic [MW-1:0] c_min_m = MW'(sat_min_m(MW));
    localparam logic [EW-1:0] c_max_e = EW'(sat_max_e(EW));

    logic          s1_valid_q, s1_valid_d;
    logic [MW-1:0] s1_m_q,     s1_m_d;
    logic [EW:0]   s1_e_q,     s1_e_d;
    logic          s1_ovf_q,   s1_ovf_d;

    logic          out_valid_q, out_valid_d;
    logic [MW-1:0] out_m_q,     out_m_d;
    logic [EW-1:0] out_e_q,     out_e_d;
    logic          out_ovf_q,   out_ovf_d;
    logic          out_unf_q,   out_unf_d;

    logic          ovf_sticky_q, ovf_sticky_d;
    logic          unf_sticky_q, unf_sticky_d;

    logic s1_load, s2_load;

    always_comb begin
        s2_load = !out_valid_q || out_ready;
        s1_load = !s1_valid_q || s2_load;
    end

    assign in_ready = s1_load;

    // ---------------- stage 1: round away the guard bit if needed ----------
    logic [MW-1:0] rnd_sum;
    logic [EW:0]   e_ext;

    always_comb begin
        e_ext      = {in_e[EW-1], in_e};
        rnd_sum    = in_m[MW:1] + MW'(in_m[0]);
        s1_valid_d = s1_valid_q;
        s1_m_d     = s1_m_q;
        s1_e_d     = s1_e_q;
        s1_ovf_d   = s1_ovf_q;
        if (s1_load) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                if (in_m[MW] ^ in_m[MW-1]) begin
                    // Rounding that would wrap the sign keeps the truncated value.
                    s1_m_d   = (rnd_sum[MW-1] != in_m[MW]) ? in_m[MW:1] : rnd_sum;
                    s1_e_d   = e_ext + (EW+1)'(1);
                    s1_ovf_d = s1_e_d[EW] ^ s1_e_d[EW-1];
                end else begin
                    s1_m_d   = in_m[MW-1:0];
                    s1_e_d   = e_ext;
                    s1_ovf_d = 1'b0;
                end
            end
        end
    end

    // ---------------- stage 2: justify and saturate ------------------------
    logic [c_shw-1:0] sh;
    logic [EW:0]      e2;
    logic [MW-1:0]    res_m;
    logic [EW-1:0]    res_e;
    logic             res_ovf, res_unf;

    fp_lsc #(.MW(MW)) u_lsc (
        .m  (s1_m_q),
        .sh (sh)
    );

    always_comb begin
        e2      = s1_e_q - (EW+1)'(sh);
        res_m   = s1_m_q << sh;
        res_e   = e2[EW-1:0];
        res_ovf = s1_ovf_q;
        res_unf = (e2[EW] ^ e2[EW-1]) & ~s1_ovf_q;
        if (s1_m_q == '0) begin
            res_m   = '0;
            res_e   = '0;
            res_ovf = 1'b0;
            res_unf = 1'b0;
        end else if (SAT != 0) begin
            if (s1_ovf_q) begin
                res_m = s1_m_q[MW-1] ? c_min_m : c_max_m;
                res_e = c_max_e;
            end else if (res_unf) begin
                res_m = '0;
                res_e = '0;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_m_d     = out_m_q;
        out_e_d     = out_e_q;
        out_ovf_d   = out_ovf_q;
        out_unf_d   = out_unf_q;
        if (s2_load) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_m_d   = res_m;
                out_e_d   = res_e;
                out_ovf_d = res_ovf;
                out_unf_d = res_unf;
            end
        end
    end

    // A flag reported on this handshake beats a simultaneous clear.
    always_comb begin
        ovf_sticky_d = (out_valid_q & out_ready & out_ovf_q) | (ovf_sticky_q & ~clr_sticky);
        unf_sticky_d = (out_valid_q & out_ready & out_unf_q) | (unf_sticky_q & ~clr_sticky);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_m_q       <= '0;
            s1_e_q       <= '0;
            s1_ovf_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_m_q      <= '0;
            out_e_q      <= '0;
            out_ovf_q    <= 1'b0;
            out_unf_q    <= 1'b0;
            ovf_sticky_q <= 1'b0;
            unf_sticky_q <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_m_q       <= s1_m_d;
            s1_e_q       <= s1_e_d;
            s1_ovf_q     <= s1_ovf_d;
            out_valid_q  <= out_valid_d;
            out_m_q      <= out_m_d;
            out_e_q      <= out_e_d;
            out_ovf_q    <= out_ovf_d;
            out_unf_q    <= out_unf_d;
            ovf_sticky_q <= ovf_sticky_d;
            unf_sticky_q <= unf_sticky_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_m      = out_m_q;
    assign out_e      = out_e_q;
    assign out_ovf    = out_ovf_q;
    assign out_unf    = out_unf_q;
    assign ovf_sticky = ovf_sticky_q;
    assign unf_sticky = unf_sticky_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_norm_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_norm_pipe
// Purpose  : Bench for fp_norm_pipe, wrapping (SAT=0) and saturating (SAT=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_norm_pipe;

    localparam int MW = 16;
    localparam int EW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          in_valid, out_ready, clr_sticky;
    logic [MW:0]   in_m;
    logic [EW-1:0] in_e;

    logic          in_ready0, out_valid0, out_ovf0, out_unf0, ovf_sticky0, unf_sticky0;
    logic [MW-1:0] out_m0;
    logic [EW-1:0] out_e0;
    logic          in_ready1, out_valid1, out_ovf1, out_unf1, ovf_sticky1, unf_sticky1;
    logic [MW-1:0] out_m1;
    logic [EW-1:0] out_e1;

    fp_norm_pipe #(.MW(MW), .EW(EW), .SAT(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_m(in_m), .in_e(in_e), .out_valid(out_valid0), .out_ready(out_ready),
        .out_m(out_m0), .out_e(out_e0), .out_ovf(out_ovf0), .out_unf(out_unf0),
        .clr_sticky(clr_sticky), .ovf_sticky(ovf_sticky0), .unf_sticky(unf_sticky0)
    );

    fp_norm_pipe #(.MW(MW), .EW(EW), .SAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_m(in_m), .in_e(in_e), .out_valid(out_valid1), .out_ready(out_ready),
        .out_m(out_m1), .out_e(out_e1), .out_ovf(out_ovf1), .out_unf(out_unf1),
        .clr_sticky(clr_sticky), .ovf_sticky(ovf_sticky1), .unf_sticky(unf_sticky1)
    );

    typedef struct {
        logic [15:0] m0; logic [7:0] e0;
        logic [15:0] m1; logic [7:0] e1;
        logic        ovf, unf;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   so = 1'b0, su = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, act, exp);
        end
    endtask

    function automatic bit fits16(input int x);
        return (x >= -32768) && (x <= 32767);
    endfunction

    // Integer-arithmetic model of round, justify, and flag/saturation rules.
    function automatic exp_t ref_model(input logic [16:0] m, input logic [7:0] e);
        int v, m1, e1, e2, sh;
        bit ovf, unf;
        exp_t r;
        v   = $signed(m);
        e1  = $signed(e);
        ovf = 1'b0;
        if (!fits16(v)) begin
            m1 = (v + 1) >>> 1;
            if (m1 > 32767) m1 = v >>> 1;
            e1  = e1 + 1;
            ovf = (e1 > 127);
        end else begin
            m1 = v;
        end
        if (m1 == 0) begin
            r.m0 = 0; r.e0 = 0; r.m1 = 0; r.e1 = 0; r.ovf = 0; r.unf = 0;
            return r;
        end
        sh = 0;
        while (sh < 15 && fits16(m1 * (1 << (sh + 1)))) sh++;
        e2  = e1 - sh;
        unf = (e2 < -128 || e2 > 127) && !ovf;
        r.m0  = 16'(m1 * (1 << sh));
        r.e0  = 8'(e2);
        r.ovf = ovf;
        r.unf = unf;
        if (ovf) begin
            r.m1 = (m1 < 0) ? 16'h8000 : 16'h7FFF;
            r.e1 = 8'h7F;
        end else if (unf) begin
            r.m1 = 16'h0;
            r.e1 = 8'h0;
        end else begin
            r.m1 = r.m0;
            r.e1 = r.e0;
        end
        return r;
    endfunction

    // One clock: sample handshakes between edges, score outputs, step the model.
    task automatic tick(output bit acc);
        exp_t x;
        bit   hs;
        #1;
        hs  = 1'b0;
        acc = in_valid && in_ready0;
        if ((out_valid0 || out_valid1) && q.size() == 0) begin
            check("spurious_out", {out_valid1, out_valid0}, 0);
        end else if (out_valid0 || out_valid1) begin
            x = q[0];
            check("m0", out_m0, x.m0);   check("e0", out_e0, x.e0);
            check("m1", out_m1, x.m1);   check("e1", out_e1, x.e1);
            check("ovf0", out_ovf0, x.ovf); check("unf0", out_unf0, x.unf);
            check("ovf1", out_ovf1, x.ovf); check("unf1", out_unf1, x.unf);
            check("valid_pair", {out_valid1, out_valid0}, 2'b11);
            if (out_ready) begin
                void'(q.pop_front());
                hs = 1'b1;
            end
        end
        if (acc) q.push_back(ref_model(in_m, in_e));
        so = (hs && x.ovf) || (so && !clr_sticky);
        su = (hs && x.unf) || (su && !clr_sticky);
        @(posedge clk);
        @(negedge clk);
        check("ovf_sticky0", ovf_sticky0, so); check("ovf_sticky1", ovf_sticky1, so);
        check("unf_sticky0", unf_sticky0, su); check("unf_sticky1", unf_sticky1, su);
    endtask

    task automatic directed(input string tag, input logic [16:0] m, input logic [7:0] e,
                            input logic [15:0] em0, input logic [7:0] ee0,
                            input logic [15:0] em1, input logic [7:0] ee1,
                            input bit eo, input bit eu);
        bit acc;
        in_valid = 1'b1; in_m = m; in_e = e; out_ready = 1'b1; clr_sticky = 1'b0;
        tick(acc);
        in_valid = 1'b0;
        check({tag, "_acc"}, acc, 1);
        check({tag, "_lat1"}, out_valid0, 0);
        tick(acc);
        check({tag, "_lat2"}, out_valid0, 1);
        check({tag, "_m0"}, out_m0, em0); check({tag, "_e0"}, out_e0, ee0);
        check({tag, "_m1"}, out_m1, em1); check({tag, "_e1"}, out_e1, ee1);
        check({tag, "_ovf"}, out_ovf0, eo); check({tag, "_unf"}, out_unf1, eu);
        tick(acc);
    endtask

    function automatic logic [16:0] rand_m();
        case ($urandom_range(0, 5))
            0:       return 17'($urandom);
            1:       return 17'($urandom_range(0, 15));
            2:       return 17'h1FFFF - 17'($urandom_range(0, 15));
            3:       return 17'h0FFFF - 17'($urandom_range(0, 3));
            4:       return 17'h10000 + 17'($urandom_range(0, 3));
            default: return 17'($urandom) >> $urandom_range(0, 16);
        endcase
    endfunction

    function automatic logic [7:0] rand_e();
        logic [7:0] bnd [4];
        bnd = '{8'h7F, 8'h80, 8'h81, 8'h00};
        if ($urandom_range(0, 2) == 0) return bnd[$urandom_range(0, 3)];
        return 8'($urandom);
    endfunction

    initial begin
        bit acc;
        int sent;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0;
        in_m = '0; in_e = '0;
        #12;
        check("rst_valid", {out_valid1, out_valid0}, 0);
        check("rst_m", {out_m1, out_m0}, 0);
        check("rst_e", {out_e1, out_e0}, 0);
        check("rst_flags", {out_ovf0, out_unf0, out_ovf1, out_unf1}, 0);
        check("rst_sticky", {ovf_sticky0, unf_sticky0, ovf_sticky1, unf_sticky1}, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready", {in_ready1, in_ready0}, 2'b11);

        directed("t1", 17'h00001, 8'h00, 16'h4000, 8'hF2, 16'h4000, 8'hF2, 0, 0);
        directed("t2", 17'h0C000, 8'h03, 16'h6000, 8'h04, 16'h6000, 8'h04, 0, 0);
        directed("t3", 17'h0FFFF, 8'h7F, 16'h7FFF, 8'h80, 16'h7FFF, 8'h7F, 1, 0);
        check("t3_sticky", {ovf_sticky1, ovf_sticky0}, 2'b11);
        directed("t4", 17'h00000, 8'h55, 16'h0000, 8'h00, 16'h0000, 8'h00, 0, 0);
        directed("t5", 17'h1FFFF, 8'h80, 16'h8000, 8'h71, 16'h0000, 8'h00, 0, 1);
        check("t5_sticky", {unf_sticky1, unf_sticky0}, 2'b11);
        clr_sticky = 1'b1;
        tick(acc);
        clr_sticky = 1'b0;
        check("clr_unf", {unf_sticky1, unf_sticky0}, 0);
        check("clr_ovf", {ovf_sticky1, ovf_sticky0}, 0);

        // Back-pressure: two beats fill the pipe, then in_ready must drop.
        sent = 0;
        out_ready = 1'b0;
        in_valid = 1'b1; in_m = rand_m(); in_e = rand_e();
        for (int c = 0; c < 40 && (sent < 6 || q.size() != 0); c++) begin
            out_ready = (c >= 4);
            in_valid  = (sent < 6);
            if (c == 2) begin
                #1;
                check("bp_in_ready", {in_ready1, in_ready0}, 0);
            end
            tick(acc);
            if (acc) begin
                sent++;
                in_m = rand_m(); in_e = rand_e();
            end
        end
        check("bp_sent", sent, 6);
        check("bp_drain", q.size(), 0);

        // Mid-stream asynchronous reset.
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1; in_m = rand_m(); in_e = rand_e();
            out_ready = (c > 3);
            tick(acc);
        end
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", {out_valid1, out_valid0}, 0);
        check("mid_rst_m", {out_m1, out_m0}, 0);
        q.delete();
        so = 1'b0; su = 1'b0;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 5; c++) tick(acc);

        // Random traffic with random stalls and sticky clears.
        in_m = rand_m(); in_e = rand_e();
        for (int c = 0; c < 400; c++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 9) < 7);
            clr_sticky = ($urandom_range(0, 9) == 0);
            tick(acc);
            if (acc || !in_valid) begin
                in_m = rand_m(); in_e = rand_e();
            end
        end
        in_valid = 1'b0; out_ready = 1'b1; clr_sticky = 1'b0;
        for (int c = 0; c < 10 && q.size() != 0; c++) tick(acc);
        check("final_drain", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
